// File: rtl/alu_ctrl.sv
// Four-phase command sequencer (IDLE/EXEC/WB/RESP) around the 4-bit combinational alu,
// with a small register file, a {Z,C,S} flag register and valid/ready command/response ports.
module alu (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [1:0] Op,
    input  logic       l,
    output logic [3:0] R,
    output logic       z,
    output logic       c,
    output logic       s
);
    logic [3:0] x;
    logic [3:0] y;
    logic       cin;
    logic [4:0] sum;

    // Every arithmetic op is x + y + cin: B+1, ~B+1, A+B, A+~B+1
    always_comb begin
        x   = Op[1] ? A : '0;
        y   = Op[0] ? ~B : B;
        cin = (Op != 2'b10);
        sum = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        R   = sum[3:0];
        c   = sum[4];
        s   = sum[3];
        if (l) begin
            c = 1'b0;
            s = 1'b0;
            case (Op)
                2'b00:   R = A & B;
                2'b01:   R = A | B;
                2'b10:   R = A ^ B;
                default: R = ~A;
            endcase
        end
        z = (R == '0);
    end
endmodule

module alu_ctrl #(
    parameter int NREG  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [11:0]      cmd,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_data,
    output logic [2:0]       rsp_flags,
    output logic             rsp_err,
    output logic [CNT_W-1:0] ops_done
);
    typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;
    typedef enum logic [1:0] {K_ALU, K_LOADI, K_READ, K_RSVD} kind_t;

    state_t           state_q, state_d;
    logic [11:0]      cmd_q;
    logic [3:0]       rf_q [NREG];
    logic [2:0]       flags_q, flags_d;
    logic [3:0]       res_q;
    logic             z_q, c_q, s_q;
    logic [3:0]       rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_flags_q;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_en;
    logic [3:0]       wr_data;

    kind_t      kind;
    logic       cmd_l;
    logic [1:0] cmd_op, rd, ra, rb;
    logic [3:0] imm;

    logic [3:0] alu_a, alu_b, alu_r;
    logic [1:0] alu_op;
    logic       alu_l, alu_z, alu_c, alu_s;

    assign kind   = kind_t'(cmd_q[11:10]);
    assign cmd_l  = cmd_q[9];
    assign cmd_op = cmd_q[8:7];
    assign rd     = cmd_q[6:5];
    assign ra     = cmd_q[4:3];
    assign rb     = cmd_q[2:1];
    assign imm    = cmd_q[3:0];

    // ALU inputs are parked at zero unless an ALU command is in flight
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        alu_l  = 1'b0;
        if (state_q != IDLE && kind == K_ALU) begin
            alu_a  = rf_q[ra];
            alu_b  = rf_q[rb];
            alu_op = cmd_op;
            alu_l  = cmd_l;
        end
    end

    alu u_alu (
        .A  (alu_a),
        .B  (alu_b),
        .Op (alu_op),
        .l  (alu_l),
        .R  (alu_r),
        .z  (alu_z),
        .c  (alu_c),
        .s  (alu_s)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Logic-mode results refresh only Z; C and S from the ALU are meaningless there
    always_comb begin
        wr_en      = 1'b0;
        wr_data    = res_q;
        flags_d    = flags_q;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        case (kind)
            K_ALU: begin
                wr_en      = 1'b1;
                rsp_data_d = res_q;
                flags_d    = cmd_l ? {z_q, flags_q[1:0]} : {z_q, c_q, s_q};
            end
            K_LOADI: begin
                wr_en      = 1'b1;
                wr_data    = imm;
                rsp_data_d = imm;
            end
            K_READ:  rsp_data_d = rf_q[rd];
            default: rsp_err_d  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            flags_q     <= '0;
            res_q       <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            s_q         <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cmd_valid) cmd_q <= cmd;
            if (state_q == EXEC) begin
                res_q <= alu_r;
                z_q   <= alu_z;
                c_q   <= alu_c;
                s_q   <= alu_s;
            end
            if (state_q == WB) begin
                if (wr_en) rf_q[rd] <= wr_data;
                flags_q     <= flags_d;
                rsp_data_q  <= rsp_data_d;
                rsp_flags_q <= flags_d;
                rsp_err_q   <= rsp_err_d;
            end
            if (state_q == RESP && rsp_ready) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;
    assign ops_done  = cnt_q;
endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: arithmetic reference model plus per-cycle output compare,
// literal test-plan sequences, backpressure, mid-command reset, full ALU sweep and random traffic.
module tb_alu_ctrl;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [11:0]      cmd;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_data;
    logic [2:0]       rsp_flags;
    logic             rsp_err;
    logic [CNT_W-1:0] ops_done;

    always #5 clk = ~clk;

    alu_ctrl #(.NREG(4), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err),
        .ops_done  (ops_done)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {logic [3:0] d; logic [2:0] f; logic e;} rsp_t;

    int          m_reg [4];
    bit          m_z, m_c, m_s;
    int unsigned m_cnt;
    bit          busy;
    int          age;
    bit          armed = 1'b0;
    int          acc_cnt = 0;
    int          n_rsp = 0;
    logic [3:0]  last_d;
    logic [2:0]  last_f;
    logic        last_e;
    rsp_t        exp_q [$];
    int          rsp_mode = 0;

    function automatic rsp_t apply(input logic [11:0] c);
        int   kind = int'(c[11:10]);
        int   lop  = int'(c[9:7]);
        int   rd   = int'(c[6:5]);
        int   a    = m_reg[int'(c[4:3])];
        int   b    = m_reg[int'(c[2:1])];
        int   x, r;
        rsp_t o;
        o.e = 1'b0;
        o.d = '0;
        case (kind)
            0: begin
                case (lop)
                    0: x = b + 1;
                    1: x = (15 - b) + 1;
                    2: x = a + b;
                    3: x = a + (15 - b) + 1;
                    4: x = a & b;
                    5: x = a | b;
                    6: x = a ^ b;
                    default: x = 15 - a;
                endcase
                r = x % 16;
                m_reg[rd] = r;
                m_z = (r == 0);
                if (lop < 4) begin
                    m_c = (x >= 16);
                    m_s = (r >= 8);
                end
                o.d = 4'(r);
            end
            1: begin
                m_reg[rd] = int'(c[3:0]);
                o.d = c[3:0];
            end
            2: o.d = 4'(m_reg[rd]);
            default: o.e = 1'b1;
        endcase
        o.f = {m_z, m_c, m_s};
        return o;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            armed = 1'b1;
            for (int i = 0; i < 4; i++) m_reg[i] = 0;
            m_z = 0; m_c = 0; m_s = 0;
            m_cnt = 0;
            busy = 0;
            age = 0;
            exp_q.delete();
        end else if (armed) begin
            if (busy) begin
                if (age >= 2 && rsp_ready) begin
                    last_d = rsp_data;
                    last_f = rsp_flags;
                    last_e = rsp_err;
                    n_rsp++;
                    void'(exp_q.pop_front());
                    m_cnt++;
                    busy = 0;
                end else if (age < 2) begin
                    age++;
                end
            end else if (cmd_valid) begin
                exp_q.push_back(apply(cmd));
                acc_cnt++;
                busy = 1;
                age = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (rst) begin
                chk("cmd_ready_in_reset", cmd_ready, 0);
            end else begin
                chk("cmd_ready", cmd_ready, !busy);
                chk("rsp_valid", rsp_valid, busy && age >= 2);
                chk("ops_done", ops_done, m_cnt % 256);
                if (busy && age >= 2 && exp_q.size() > 0) begin
                    chk("rsp_data", rsp_data, exp_q[0].d);
                    chk("rsp_flags", rsp_flags, exp_q[0].f);
                    chk("rsp_err", rsp_err, exp_q[0].e);
                end
            end
        end
    end

    always @(negedge clk)
        rsp_ready = (rsp_mode == 0) ? 1'b1 : ((rsp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);

    // ---------------- stimulus helpers ----------------
    function automatic logic [11:0] f_alu(input int l, input int op, input int rd, input int ra, input int rb);
        return {2'b00, 1'(l), 2'(op), 2'(rd), 2'(ra), 2'(rb), 1'b0};
    endfunction

    function automatic logic [11:0] f_loadi(input int rd, input int imm);
        return {2'b01, 3'b000, 2'(rd), 1'b0, 4'(imm)};
    endfunction

    function automatic logic [11:0] f_read(input int rd);
        return {2'b10, 3'b000, 2'(rd), 5'b00000};
    endfunction

    // Called at a negedge; returns at the negedge after acceptance with the command still offered.
    task automatic send(input logic [11:0] c);
        int a0 = acc_cnt;
        bit ok = 1'b0;
        cmd = c;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (acc_cnt != a0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic lit(input string name, input logic [11:0] c, input logic [3:0] d,
                       input logic [2:0] f, input logic e);
        int n0 = n_rsp;
        bit ok = 1'b0;
        send(c);
        cmd_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (n_rsp != n0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_timeout"}, 0, 1);
        chk({name, "_data"}, last_d, d);
        chk({name, "_flags"}, last_f, f);
        chk({name, "_err"}, last_e, e);
    endtask

    initial begin
        int unsigned c0;
        int          n0;
        bit          ok;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_flags", rsp_flags, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_ops_done", ops_done, 0);

        lit("loadi_r0_5", f_loadi(0, 5), 4'h5, 3'b000, 1'b0);
        lit("loadi_r1_3", f_loadi(1, 3), 4'h3, 3'b000, 1'b0);
        lit("sub_5_3", f_alu(0, 3, 2, 0, 1), 4'h2, 3'b010, 1'b0);
        lit("read_r2", f_read(2), 4'h2, 3'b010, 1'b0);
        lit("loadi_r0_9", f_loadi(0, 9), 4'h9, 3'b010, 1'b0);
        lit("loadi_r1_7", f_loadi(1, 7), 4'h7, 3'b010, 1'b0);
        lit("add_wrap", f_alu(0, 2, 2, 0, 1), 4'h0, 3'b110, 1'b0);
        lit("neg_zero", f_alu(0, 1, 2, 0, 3), 4'h0, 3'b110, 1'b0);
        lit("loadi_r0_3", f_loadi(0, 3), 4'h3, 3'b110, 1'b0);
        lit("loadi_r1_5", f_loadi(1, 5), 4'h5, 3'b110, 1'b0);
        lit("sub_3_5", f_alu(0, 3, 2, 0, 1), 4'hE, 3'b001, 1'b0);
        lit("and_keeps_cs", f_alu(1, 0, 2, 1, 0), 4'h1, 3'b001, 1'b0);
        lit("loadi_r3_f", f_loadi(3, 15), 4'hF, 3'b001, 1'b0);
        lit("not_keeps_cs", f_alu(1, 3, 2, 3, 0), 4'h0, 3'b101, 1'b0);
        lit("inc_rd_eq_ra", f_alu(0, 0, 3, 3, 3), 4'h0, 3'b110, 1'b0);

        // Backpressure: response must hold while rsp_ready is low
        rsp_mode = 2;
        @(negedge clk);
        send(f_loadi(1, 10));
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("bp_rsp_timeout", 0, 1);
        c0 = m_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 4'hA);
            chk("bp_flags", rsp_flags, 3'b110);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_ops_hold", ops_done, c0 % 256);
        end
        n0 = n_rsp;
        rsp_mode = 0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (n_rsp != n0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("bp_release_timeout", 0, 1);
        chk("bp_ops_inc", ops_done, (c0 + 1) % 256);
        repeat (3) @(negedge clk);
        chk("bp_ops_once", ops_done, (c0 + 1) % 256);

        // Reset during WB of LOADI r3=F, with a command offered in the reset cycle
        send(f_loadi(3, 15));
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cmd = f_read(0);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_no_rsp", rsp_valid, 0);
        chk("rst_ops", ops_done, 0);
        repeat (4) @(negedge clk);
        chk("rst_still_no_rsp", n_rsp, n0 + 1);
        lit("read_r3_after_rst", f_read(3), 4'h0, 3'b000, 1'b0);
        lit("reserved", {2'b11, 10'h3FF}, 4'h0, 3'b000, 1'b1);

        // Full sweep over l, op, A, B
        for (int a = 0; a < 16; a++) begin
            send(f_loadi(0, a));
            for (int b = 0; b < 16; b++) begin
                send(f_loadi(1, b));
                for (int lo = 0; lo < 8; lo++)
                    send(f_alu(lo / 4, lo % 4, 2 + $urandom_range(0, 1), 0, 1));
            end
        end

        // Random traffic with random backpressure and idle gaps
        rsp_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge clk);
            end
            send(12'($urandom));
        end
        cmd_valid = 1'b0;
        rsp_mode = 0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
